// File: rtl/seg_pkg.sv
// Shared types and constant helpers for the multiplexed 7-segment feeder.
package seg_pkg;

  typedef logic [3:0] digit_t;

  localparam digit_t BLANK_CODE = 4'hF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    COMMIT  = 2'd2
  } state_t;

  // Largest value representable in nd decimal digits (10^nd - 1).
  function automatic longint unsigned max_display(input int unsigned nd);
    longint unsigned v;
    v = 64'd1;
    for (int i = 0; i < int'(nd); i++) begin
      v = v * 64'd10;
    end
    return v - 64'd1;
  endfunction

  // Decimal digits needed to hold any bw-bit binary value.
  function automatic int unsigned dec_digits(input int unsigned bw);
    longint unsigned top;
    int unsigned     n;
    top = (64'd1 << bw) - 64'd1;
    n   = 1;
    while (max_display(n) < top) begin
      n = n + 1;
    end
    return n;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: one shift-add-3 iteration per clock, BIN_W iterations.
// Digits beyond NUM_DIGITS are folded into carry for overflow detection.
module bin2bcd_seq
  import seg_pkg::*;
#(
  parameter int unsigned BIN_W      = 14,
  parameter int unsigned NUM_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [BIN_W-1:0]        bin,
  output logic [NUM_DIGITS*4-1:0] bcd,
  output logic                    carry,
  output logic                    done_c
);

  localparam int unsigned NEED_D = dec_digits(BIN_W);
  localparam int unsigned TOT_D  = (NEED_D > NUM_DIGITS) ? NEED_D : NUM_DIGITS + 1;
  localparam int unsigned BCD_W  = TOT_D * 4;
  localparam int unsigned OUT_W  = NUM_DIGITS * 4;
  localparam int unsigned CNT_W  = $clog2(BIN_W + 1);

  logic [BIN_W-1:0] shreg;
  logic [BCD_W-1:0] acc;
  logic [BCD_W-1:0] adj;
  logic [CNT_W-1:0] cnt;
  logic             active;

  // Add 3 to every digit >= 5 ahead of the shift.
  always_comb begin
    adj = acc;
    for (int i = 0; i < int'(TOT_D); i++) begin
      if (acc[i*4 +: 4] >= 4'd5) begin
        adj[i*4 +: 4] = acc[i*4 +: 4] + 4'd3;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg  <= '0;
      acc    <= '0;
      cnt    <= '0;
      active <= 1'b0;
    end else if (start) begin
      shreg  <= bin;
      acc    <= '0;
      cnt    <= CNT_W'(BIN_W);
      active <= 1'b1;
    end else if (active) begin
      {acc, shreg} <= {adj[BCD_W-2:0], shreg, 1'b0};
      cnt          <= cnt - CNT_W'(1);
      if (cnt == CNT_W'(1)) begin
        active <= 1'b0;
      end
    end
  end

  assign done_c = active && (cnt == CNT_W'(1));
  assign bcd    = acc[OUT_W-1:0];
  assign carry  = |acc[BCD_W-1:OUT_W];

endmodule

// File: rtl/seg_scan_driver.sv
// Binary-to-BCD front end plus time-multiplexed digit scanner for a 7-seg decoder.
// Optional build macro: SEG_LEADING_ZERO_BLANK_EN blanks leading zero digits at commit.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned BIN_W      = 14,
  parameter int unsigned SCAN_DIV   = 50000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [BIN_W-1:0]      bin_in,
  input  logic                  bin_valid,
  output logic                  bin_ready,
  output logic [3:0]            digit_code,
  output logic [NUM_DIGITS-1:0] digit_sel,
  output logic                  busy,
  output logic                  overflow
);

  localparam int unsigned PRE_W = $clog2(SCAN_DIV);
  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  state_t state;
  state_t state_next;
  logic   start_c;
  logic   commit_c;
  logic   done_c;

  logic [NUM_DIGITS*4-1:0] bcd;
  logic                    carry;

  digit_t digits        [NUM_DIGITS];
  digit_t commit_digits [NUM_DIGITS];

  logic [PRE_W-1:0] presc;
  logic [IDX_W-1:0] scan_idx;
  logic             wrap_c;

  bin2bcd_seq #(
    .BIN_W      (BIN_W),
    .NUM_DIGITS (NUM_DIGITS)
  ) u_bin2bcd (
    .clk    (clk),
    .rst    (rst),
    .start  (start_c),
    .bin    (bin_in),
    .bcd    (bcd),
    .carry  (carry),
    .done_c (done_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bin_ready <= 1'b1;
      busy      <= 1'b0;
    end else begin
      state     <= state_next;
      bin_ready <= (state_next == IDLE);
      busy      <= (state_next == CONVERT);
    end
  end

  always_comb begin
    state_next = state;
    start_c    = 1'b0;
    commit_c   = 1'b0;
    case (state)
      IDLE: begin
        if (bin_valid && bin_ready) begin
          start_c    = 1'b1;
          state_next = CONVERT;
        end
      end
      CONVERT: begin
        if (done_c) begin
          state_next = COMMIT;
        end
      end
      COMMIT: begin
        commit_c   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Digit values to store at commit: overflow blanks all, optionally blank leading zeros.
  always_comb begin
`ifdef SEG_LEADING_ZERO_BLANK_EN
    logic seen_nz;
    seen_nz = 1'b0;
`endif
    for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
      commit_digits[i] = digit_t'(bcd[i*4 +: 4]);
`ifdef SEG_LEADING_ZERO_BLANK_EN
      if (bcd[i*4 +: 4] != 4'd0) begin
        seen_nz = 1'b1;
      end else if (!seen_nz && (i != 0)) begin
        commit_digits[i] = BLANK_CODE;
      end
`endif
      if (carry) begin
        commit_digits[i] = BLANK_CODE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_DIGITS); i++) begin
        digits[i] <= '0;
      end
      overflow <= 1'b0;
    end else if (commit_c) begin
      digits   <= commit_digits;
      overflow <= carry;
    end
  end

  assign wrap_c = (presc == PRE_W'(SCAN_DIV - 1));

  // Scanner runs independently of the conversion FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc      <= '0;
      scan_idx   <= '0;
      digit_sel  <= NUM_DIGITS'(1);
      digit_code <= '0;
    end else begin
      presc <= wrap_c ? '0 : presc + PRE_W'(1);
      if (wrap_c) begin
        scan_idx <= (scan_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : scan_idx + IDX_W'(1);
      end
      digit_sel  <= NUM_DIGITS'(1) << scan_idx;
      digit_code <= digits[scan_idx];
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed self-checking bench for seg_scan_driver (SCAN_DIV=4, 4 digits, 14-bit input).
module tb_seg_scan_driver;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned BIN_W      = 14;
  localparam int unsigned SCAN_DIV   = 4;

  logic                  clk;
  logic                  rst;
  logic [BIN_W-1:0]      bin_in;
  logic                  bin_valid;
  logic                  bin_ready;
  logic [3:0]            digit_code;
  logic [NUM_DIGITS-1:0] digit_sel;
  logic                  busy;
  logic                  overflow;

  int unsigned checks;
  int unsigned errors;

  seg_scan_driver #(
    .NUM_DIGITS (NUM_DIGITS),
    .BIN_W      (BIN_W),
    .SCAN_DIV   (SCAN_DIV)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bin_in     (bin_in),
    .bin_valid  (bin_valid),
    .bin_ready  (bin_ready),
    .digit_code (digit_code),
    .digit_sel  (digit_sel),
    .busy       (busy),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Observe one full scan period; exp holds digit3..digit0 as nibbles.
  task automatic scan_check(input string tag, input logic [15:0] exp);
    int          cnt [NUM_DIGITS];
    int          idx;
    logic [15:0] e;
    e = exp;
    for (int i = 0; i < int'(NUM_DIGITS); i++) cnt[i] = 0;
    @(negedge clk);
    for (int c = 0; c < int'(SCAN_DIV * NUM_DIGITS); c++) begin
      check({tag, " onehot"}, 32'($onehot(digit_sel)), 32'd1);
      idx = 0;
      for (int i = 0; i < int'(NUM_DIGITS); i++) if (digit_sel[i]) idx = i;
      check($sformatf("%s code[%0d]", tag, idx), 32'(digit_code), 32'(e[idx*4 +: 4]));
      cnt[idx]++;
      @(negedge clk);
    end
    for (int i = 0; i < int'(NUM_DIGITS); i++)
      check($sformatf("%s hold[%0d]", tag, i), 32'(cnt[i]), 32'(SCAN_DIV));
  endtask

  // Wait (bounded) for bin_ready, counting low and busy cycles.
  task automatic wait_ready(input string tag);
    int nl;
    int nb;
    nl = 0;
    nb = 0;
    while (!bin_ready && nl < 40) begin
      nl++;
      if (busy) nb++;
      @(negedge clk);
    end
    check({tag, " ready_low_cycles"}, 32'(nl), 32'd15);
    check({tag, " busy_cycles"}, 32'(nb), 32'd14);
  endtask

  task automatic send(input string tag, input logic [BIN_W-1:0] v,
                      input logic [15:0] exp, input logic exp_ovf);
    @(negedge clk);
    bin_in    = v;
    bin_valid = 1'b1;
    @(negedge clk);
    bin_valid = 1'b0;
    wait_ready(tag);
    check({tag, " overflow"}, 32'(overflow), 32'(exp_ovf));
    scan_check(tag, exp);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    bin_in    = '0;
    bin_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst digit_sel", 32'(digit_sel), 32'h1);
    check("rst digit_code", 32'(digit_code), 32'h0);
    check("rst bin_ready", 32'(bin_ready), 32'h1);
    check("rst busy", 32'(busy), 32'h0);
    check("rst overflow", 32'(overflow), 32'h0);
    rst = 1'b0;

    send("v1234", 14'd1234, 16'h1234, 1'b0);
`ifdef SEG_LEADING_ZERO_BLANK_EN
    send("v7", 14'd7, 16'hFFF7, 1'b0);
    send("v0", 14'd0, 16'hFFF0, 1'b0);
`else
    send("v7", 14'd7, 16'h0007, 1'b0);
    send("v0", 14'd0, 16'h0000, 1'b0);
`endif
    send("v10000", 14'd10000, 16'hFFFF, 1'b1);
    send("v9999", 14'd9999, 16'h9999, 1'b0);
    send("v12000", 14'd12000, 16'hFFFF, 1'b1);

    // Reset in the middle of a conversion discards it.
    @(negedge clk);
    bin_in    = 14'd5555;
    bin_valid = 1'b1;
    @(negedge clk);
    bin_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("midrst busy_before", 32'(busy), 32'h1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst digit_sel", 32'(digit_sel), 32'h1);
    check("midrst digit_code", 32'(digit_code), 32'h0);
    check("midrst bin_ready", 32'(bin_ready), 32'h1);
    check("midrst busy", 32'(busy), 32'h0);
    check("midrst overflow", 32'(overflow), 32'h0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("midrst no_commit_ovf", 32'(overflow), 32'h0);
    check("midrst idle", 32'(bin_ready), 32'h1);
    scan_check("midrst", 16'h0000);

    // Valid held through CONVERT with a changing value: first one wins.
    @(negedge clk);
    bin_in    = 14'd42;
    bin_valid = 1'b1;
    @(negedge clk);
    bin_in    = 14'd99;
    wait_ready("held");
    bin_valid = 1'b0;
    check("held overflow", 32'(overflow), 32'h0);
`ifdef SEG_LEADING_ZERO_BLANK_EN
    scan_check("held", 16'hFF42);
    send("v99", 14'd99, 16'hFF99, 1'b0);
`else
    scan_check("held", 16'h0042);
    send("v99", 14'd99, 16'h0099, 1'b0);
`endif
    send("v16383", 14'd16383, 16'hFFFF, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
